// File: rtl/pipeline_debug_controller.sv
// Debug sequencer for the five-stage pipeline: RUN/STEP/DUMP/CLEAR command
// handling, global pipe enable, saturating cycle counter, halt/timeout
// detection and a valid/ready dump stream of the register file + cycle count.
module pipeline_debug_controller #(
  parameter int len        = 32,
  parameter int NREGS      = 32,
  parameter int NB         = $clog2(NREGS),
  parameter int MAX_CYCLES = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  input  logic [1:0]     cmd_code,
  output logic           cmd_ready,
  input  logic           halt_detected,
  output logic           pipe_enable,
  output logic [NB-1:0]  dbg_reg_addr,
  input  logic [len-1:0] dbg_reg_data,
  output logic           dump_valid,
  output logic [len-1:0] dump_data,
  input  logic           dump_ready,
  output logic           done,
  output logic           timeout,
  output logic [len-1:0] cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_DUMP, S_DONE} state_t;

  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_DUMP  = 2'b11;

  // word index runs 0..NREGS, one past the register file for the count word
  localparam int IW = $clog2(NREGS + 1);

  state_t         state_q, state_d, ret_q, ret_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [NB-1:0]  addr_q, addr_d;
  logic           pe_q, pe_d, dv_q, dv_d, done_q, done_d, to_q, to_d;
  logic [len-1:0] cnt_q, cnt_d, cnt_inc;
  logic           cmd_fire, dump_fire, last_word, cnt_hit_max;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign dump_fire = dv_q & dump_ready;
  assign last_word = (idx_q == IW'(NREGS));
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // timeout compare only exists when a limit is configured
  if (MAX_CYCLES == 0) begin : g_nomax
    assign cnt_hit_max = 1'b0;
  end else begin : g_max
    assign cnt_hit_max = (cnt_inc >= len'(MAX_CYCLES));
  end

  // next-state and next-output computation for the sequencer
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    pe_d    = pe_q;
    dv_d    = dv_q;
    done_d  = done_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_code)
            C_CLEAR: begin
              cnt_d  = '0;
              done_d = 1'b0;
              to_d   = 1'b0;
            end
            C_RUN: begin
              state_d = S_RUN;
              pe_d    = 1'b1;
            end
            C_STEP: begin
              state_d = S_STEP;
              pe_d    = 1'b1;
            end
            default: begin
              state_d = S_DUMP;
              ret_d   = S_IDLE;
              dv_d    = 1'b1;
              idx_d   = '0;
              addr_d  = '0;
            end
          endcase
        end
      end
      S_RUN: begin
        // every RUN cycle is enabled, so it is counted even when it ends the run
        cnt_d = cnt_inc;
        if (halt_detected) begin
          done_d  = 1'b1;
          pe_d    = 1'b0;
          state_d = S_DONE;
        end else if (cnt_hit_max) begin
          done_d  = 1'b1;
          to_d    = 1'b1;
          pe_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_STEP: begin
        cnt_d = cnt_inc;
        pe_d  = 1'b0;
        if (halt_detected) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DUMP: begin
        if (dump_fire) begin
          if (last_word) begin
            dv_d    = 1'b0;
            idx_d   = '0;
            addr_d  = '0;
            state_d = ret_q;
          end else begin
            idx_d  = idx_q + 1'b1;
            addr_d = NB'(idx_q + 1'b1);
          end
        end
      end
      S_DONE: begin
        // RUN/STEP are handshaken but have no effect here
        if (cmd_fire) begin
          if (cmd_code == C_CLEAR) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            to_d    = 1'b0;
          end else if (cmd_code == C_DUMP) begin
            state_d = S_DUMP;
            ret_d   = S_DONE;
            dv_d    = 1'b1;
            idx_d   = '0;
            addr_d  = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pe_d    = 1'b0;
        dv_d    = 1'b0;
      end
    endcase
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      pe_q    <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      pe_q    <= pe_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign pipe_enable  = pe_q;
  assign dbg_reg_addr = addr_q;
  assign dump_valid   = dv_q;
  assign dump_data    = last_word ? cnt_q : dbg_reg_data;
  assign done         = done_q;
  assign timeout      = to_q;
  assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Bench for pipeline_debug_controller: three instances (no timeout, MAX_CYCLES=8,
// narrow 4-bit counter) sharing stimulus; table vectors plus directed sequences.
module tb_pipeline_debug_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_code = 2'b00;
  logic halt = 1'b0;
  logic dump_ready = 1'b0;

  always #5 clk = ~clk;

  logic        cr0, pe0, dv0, done0, to0;
  logic [4:0]  addr0;
  logic [31:0] rd0, dd0, cnt0;
  logic        cr1, pe1, dv1, done1, to1;
  logic [4:0]  addr1;
  logic [31:0] rd1, dd1, cnt1;
  logic        cr2, pe2, dv2, done2, to2;
  logic [1:0]  addr2;
  logic [3:0]  rd2, dd2, cnt2;

  // register file model: r[k] = k*4
  assign rd0 = 32'(addr0) * 32'd4;
  assign rd1 = 32'(addr1) * 32'd4;
  assign rd2 = {addr2, 2'b00};

  pipeline_debug_controller #(.len(32), .NREGS(32), .MAX_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cr0),
    .halt_detected(halt), .pipe_enable(pe0), .dbg_reg_addr(addr0), .dbg_reg_data(rd0),
    .dump_valid(dv0), .dump_data(dd0), .dump_ready(dump_ready), .done(done0),
    .timeout(to0), .cycle_count(cnt0));

  pipeline_debug_controller #(.len(32), .NREGS(32), .MAX_CYCLES(8)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cr1),
    .halt_detected(halt), .pipe_enable(pe1), .dbg_reg_addr(addr1), .dbg_reg_data(rd1),
    .dump_valid(dv1), .dump_data(dd1), .dump_ready(dump_ready), .done(done1),
    .timeout(to1), .cycle_count(cnt1));

  pipeline_debug_controller #(.len(4), .NREGS(4), .MAX_CYCLES(0)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cr2),
    .halt_detected(halt), .pipe_enable(pe2), .dbg_reg_addr(addr2), .dbg_reg_data(rd2),
    .dump_valid(dv2), .dump_data(dd2), .dump_ready(dump_ready), .done(done2),
    .timeout(to2), .cycle_count(cnt2));

  typedef struct {
    logic        cv;
    logic [1:0]  code;
    logic        halt;
    logic        pe;
    logic [31:0] cnt;
    logic        rdy;
    logic        done;
  } vec_t;

  vec_t tbl [14];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd_code  = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_code  = 2'b00;
  endtask

  task automatic do_reset();
    halt = 1'b0;
    dump_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // stream a dump from dut0 and check every accepted word against a scoreboard
  task automatic dump_check(input bit toggle, input logic [31:0] final_cnt, input logic exp_done);
    logic [31:0] sb [$];
    int guard;
    bit r;
    for (int k = 0; k < 32; k++) sb.push_back(32'(k) * 32'd4);
    sb.push_back(final_cnt);
    guard = 0;
    r = 1'b1;
    cmd(2'b11);
    while (sb.size() > 0 && guard < 300) begin
      dump_ready = r;
      chk("dump pe", 32'(pe0), 0);
      if (!dv0) begin
        chk("dump valid", 32'(dv0), 1);
        break;
      end else if (r) begin
        chk($sformatf("dump word %0d", 33 - sb.size()), dd0, sb.pop_front());
      end else begin
        chk("dump held", dd0, sb[0]);
      end
      @(negedge clk);
      guard++;
      if (toggle) r = ~r;
    end
    dump_ready = 1'b0;
    chk("dump remaining", 32'(sb.size()), 0);
    chk("dump end valid", 32'(dv0), 0);
    chk("dump end ready", 32'(cr0), 1);
    chk("dump end done", 32'(done0), 32'(exp_done));
    chk("dump end count", cnt0, final_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //            cv code halt  pe cnt rdy done
    tbl[0]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'd2, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'd3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b0, 32'd3, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'd1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0};

    // reset state
    @(negedge clk);
    chk("rst pe", 32'(pe0), 0);
    chk("rst cnt", cnt0, 0);
    chk("rst done", 32'(done0), 0);
    chk("rst timeout", 32'(to0), 0);
    chk("rst dump_valid", 32'(dv0), 0);
    chk("rst addr", 32'(addr0), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst ready", 32'(cr0), 1);

    // async reset in the middle of a RUN
    cmd(2'b01);
    repeat (4) @(negedge clk);
    chk("run pe before rst", 32'(pe0), 1);
    chk("run cnt before rst", cnt0, 4);
    #2 reset = 1'b0;
    #1;
    chk("midrun rst pe", 32'(pe0), 0);
    chk("midrun rst cnt", cnt0, 0);
    chk("midrun rst ready", 32'(cr0), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post rst pe", 32'(pe0), 0);
    chk("post rst ready", 32'(cr0), 1);

    // STEP / CLEAR / halt vectors
    for (int i = 0; i < 14; i++) begin
      cmd_valid = tbl[i].cv;
      cmd_code  = tbl[i].code;
      halt      = tbl[i].halt;
      @(negedge clk);
      chk($sformatf("vec%0d pe", i), 32'(pe0), 32'(tbl[i].pe));
      chk($sformatf("vec%0d cnt", i), cnt0, tbl[i].cnt);
      chk($sformatf("vec%0d ready", i), 32'(cr0), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d done", i), 32'(done0), 32'(tbl[i].done));
    end
    cmd_valid = 1'b0;
    halt = 1'b0;

    // RUN with halt in the 10th enabled cycle, then DUMP from DONE
    do_reset();
    cmd(2'b01);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("run c%0d pe", c), 32'(pe0), 1);
      chk($sformatf("run c%0d cnt", c), cnt0, 32'(c - 1));
      if (c == 10) halt = 1'b1;
      @(negedge clk);
    end
    halt = 1'b0;
    chk("halt cnt", cnt0, 10);
    chk("halt done", 32'(done0), 1);
    chk("halt pe", 32'(pe0), 0);
    chk("halt timeout", 32'(to0), 0);
    chk("halt ready", 32'(cr0), 1);
    cmd(2'b01);
    chk("done run ignored pe", 32'(pe0), 0);
    @(negedge clk);
    chk("done run ignored cnt", cnt0, 10);
    chk("done run ignored done", 32'(done0), 1);
    dump_check(1'b0, 32'd10, 1'b1);
    cmd(2'b00);
    chk("clear done", 32'(done0), 0);
    chk("clear cnt", cnt0, 0);
    chk("clear ready", 32'(cr0), 1);

    // MAX_CYCLES=8 timeout then CLEAR
    do_reset();
    cmd(2'b01);
    n = 0;
    while (!done1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout latency", 32'(n), 8);
    chk("timeout cnt", cnt1, 8);
    chk("timeout flag", 32'(to1), 1);
    chk("timeout done", 32'(done1), 1);
    chk("timeout pe", 32'(pe1), 0);
    cmd(2'b00);
    chk("to clear done", 32'(done1), 0);
    chk("to clear timeout", 32'(to1), 0);
    chk("to clear cnt", cnt1, 0);
    chk("to clear ready", 32'(cr1), 1);
    chk("to clear pe", 32'(pe1), 0);

    // halt coinciding with the timeout cycle: halt wins
    do_reset();
    cmd(2'b01);
    repeat (7) @(negedge clk);
    chk("coinc pre cnt", cnt1, 7);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("coinc done", 32'(done1), 1);
    chk("coinc timeout", 32'(to1), 0);
    chk("coinc cnt", cnt1, 8);

    // DUMP from IDLE with dump_ready toggling
    do_reset();
    cmd(2'b10);
    @(negedge clk);
    cmd(2'b10);
    @(negedge clk);
    chk("pre dump cnt", cnt0, 2);
    dump_check(1'b1, 32'd2, 1'b0);

    // counter saturation on the narrow instance
    do_reset();
    cmd(2'b01);
    repeat (20) @(negedge clk);
    chk("sat cnt4", 32'(cnt2), 15);
    chk("sat pe4", 32'(pe2), 1);
    chk("wide cnt", cnt0, 20);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("sat halt done4", 32'(done2), 1);
    chk("sat halt cnt4", 32'(cnt2), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
